rsa_modexp: RTL and testbench

- Modular exponentiation engine for the RSA datapath: computes y = base^exp mod N using left-to-right square-and-multiply.
- It is the initiator-side counterpart of the modular multiplier. It issues all multiply operations itself, using an embedded bit-serial interleaved modular multiplier, and returns the result with a start/done handshake.
- It sits between the key/message registers and the cipher output register.

---
 rtl/rsa_modexp.sv | 142 ++++++++++++++
 tb/tb_rsa_modexp.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp.sv
// Modular exponentiation y = base^exp mod N by left-to-right square-and-multiply,
// driving an embedded bit-serial interleaved modular multiplier.
module rsa_modexp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] y,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [2:0]       stateO
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        SQUARE = 3'd2,
        MULT   = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] base_r, exp_r, n_r, r_r;
    logic [WIDTH-1:0] mb;      // multiplier B operand, consumed MSB first
    logic [WIDTH-1:0] p;       // running partial product, always < N
    logic [WIDTH-1:0] a_sel, p_nxt;
    logic [IW-1:0]    cnt, idx;
    logic             last;

    // One interleaved step: P = 2P mod N, then optionally P = (P + A) mod N.
    // Both sums stay below 2N, so WIDTH+2 bits never overflow.
    function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] pv,
                                                 input logic [WIDTH-1:0] av,
                                                 input logic [WIDTH-1:0] nv,
                                                 input logic             bv);
        logic [WIDTH+1:0] t;
        logic [WIDTH+1:0] nn;
        nn = {2'b00, nv};
        t  = {1'b0, pv, 1'b0};
        if (t >= nn) t = t - nn;
        if (bv) begin
            t = t + {2'b00, av};
            if (t >= nn) t = t - nn;
        end
        return t[WIDTH-1:0];
    endfunction

    always_comb begin
        a_sel = (state == REDUCE) ? WIDTH'(1) : r_r;
        p_nxt = mm_step(p, a_sel, n_r, mb[WIDTH-1]);
        last  = (cnt == IW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = (N == '0) ? ERROR : REDUCE;
            REDUCE:  if (last) nxt = SQUARE;
            SQUARE:  if (last) begin
                         if (exp_r[idx])      nxt = MULT;
                         else if (idx == '0)  nxt = DONE;
                         else                 nxt = SQUARE;
                     end
            MULT:    if (last) nxt = (idx == '0) ? DONE : SQUARE;
            DONE:    nxt = IDLE;
            ERROR:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r <= '0;
            exp_r  <= '0;
            n_r    <= '0;
            r_r    <= '0;
            mb     <= '0;
            p      <= '0;
            cnt    <= '0;
            idx    <= '0;
            y      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base_r <= base;
                    exp_r  <= exp;
                    n_r    <= N;
                    r_r    <= (N == WIDTH'(1)) ? '0 : WIDTH'(1);
                    idx    <= IW'(WIDTH - 1);
                    mb     <= base;
                    p      <= '0;
                    cnt    <= '0;
                end
                REDUCE, SQUARE, MULT: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (!last) begin
                        p  <= p_nxt;
                        mb <= {mb[WIDTH-2:0], 1'b0};
                    end else begin
                        p <= '0;
                        if (state == REDUCE) begin
                            base_r <= p_nxt;
                            mb     <= r_r;
                        end else begin
                            r_r <= p_nxt;
                            // A pending multiply reuses the same exponent bit
                            if (state == SQUARE && exp_r[idx]) begin
                                mb <= base_r;
                            end else begin
                                mb  <= p_nxt;
                                idx <= idx - 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase

            if (nxt == DONE)       y <= p_nxt;
            else if (nxt == ERROR) y <= '0;
        end
    end

    assign busy   = (state == REDUCE) || (state == SQUARE) || (state == MULT);
    assign done   = (state == DONE);
    assign err    = (state == ERROR);
    assign stateO = state;

endmodule

// File: tb/tb_rsa_modexp.sv
// Randomized and directed bench for rsa_modexp against a plain-arithmetic modexp model.
module tb_rsa_modexp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = '0, ex = '0, n = '0;
    logic [31:0] y;
    logic        done, busy, err;
    logic [2:0]  stateO;

    int nchk = 0;
    int nerr = 0;

    rsa_modexp #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exp(ex), .N(n),
        .y(y), .done(done), .busy(busy), .err(err), .stateO(stateO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nchk++;
        if (obs !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] e,
                                               input logic [31:0] m);
        logic [63:0] r, bb, mm;
        if (m == 0) return 32'd0;
        mm = {32'd0, m};
        bb = {32'd0, b} % mm;
        r  = 64'd1 % mm;
        for (int i = 31; i >= 0; i--) begin
            r = (r * r) % mm;
            if (e[i]) r = (r * bb) % mm;
        end
        return r[31:0];
    endfunction

    function automatic int exp_lat(input logic [31:0] e);
        return 1 + 32 * (1 + 32 + $countones(e));
    endfunction

    // Called at #1 after an edge with the DUT idle; returns #1 after the sampling edge.
    task automatic launch(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        base  = b;
        ex    = e;
        n     = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input bit scr, output int cyc, output bit busy_ok);
        cyc     = 1;
        busy_ok = (busy === 1'b1);
        while (!(done === 1'b1 || err === 1'b1) && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            if (!(done === 1'b1 || err === 1'b1)) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (scr) begin
                    base  = $urandom;
                    ex    = $urandom;
                    n     = $urandom;
                    start = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] b, input logic [31:0] e,
                         input logic [31:0] m, input logic [31:0] expy);
        int cyc;
        bit bok;
        launch(b, e, m);
        wait_end(1'b0, cyc, bok);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_y"}, 64'(y), 64'(expy));
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat(e)));
        chk({tag, "_busy"}, 64'(bok), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int          cyc;
        bit          bok;
        logic [31:0] rb, re, rm;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_state", 64'(stateO), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("t23", 32'd23, 32'd31, 32'd29, 32'd16);
        do_op("t445", 32'd4, 32'd13, 32'd497, 32'd445);
        repeat (3) @(posedge clk);
        #1;
        chk("hold445", 64'(y), 64'd445);
        do_op("tbig_base", 32'd100, 32'd1, 32'd7, 32'd2);
        do_op("texp0", 32'h12345, 32'd0, 32'd1000, 32'd1);
        do_op("tn1", 32'd5, 32'd3, 32'd1, 32'd0);
        do_op("tmax", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFB, 32'd16);

        // Asynchronous reset in the middle of a computation
        launch(32'd23, 32'd31, 32'd29);
        repeat (499) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_y", 64'(y), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_state", 64'(stateO), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("trerun", 32'd23, 32'd31, 32'd29, 32'd16);

        // Inputs and start scrambled while busy; start also raised in DONE
        launch(32'd23, 32'd31, 32'd29);
        wait_end(1'b1, cyc, bok);
        start = 1'b1;
        base  = 32'd3;
        ex    = 32'd3;
        n     = 32'd0;
        chk("scr_done", 64'(done), 64'd1);
        chk("scr_y", 64'(y), 64'd16);
        chk("scr_lat", 64'(cyc), 64'(exp_lat(32'd31)));
        chk("scr_busy", 64'(bok), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_done_state", 64'(stateO), 64'd0);
        chk("ign_done_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        chk("ign_done_idle", 64'(stateO), 64'd0);

        for (int k = 0; k < 6; k++) begin
            rb = $urandom;
            re = $urandom;
            rm = $urandom;
            if (k == 4) rm = 32'($urandom_range(1, 50));
            if (k[0]) rm = rm | 32'd1;
            else      rm = rm & ~32'd1;
            if (rm == 0) rm = 32'd6;
            do_op($sformatf("rnd%0d", k), rb, re, rm, ref_modexp(rb, re, rm));
        end

        // Zero modulus
        launch(32'd7, 32'd9, 32'd0);
        chk("nz_err", 64'(err), 64'd1);
        chk("nz_done", 64'(done), 64'd0);
        chk("nz_y", 64'(y), 64'd0);
        chk("nz_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("nz_err_pulse", 64'(err), 64'd0);
        chk("nz_state", 64'(stateO), 64'd0);
        chk("nz_done2", 64'(done), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
